// File: rtl/zegar_pkg.sv
// Shared types and constants for the BCD time-of-day counter.
// Field limits are BCD-encoded so they compare directly against counter values.
package zegar_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_field_t;

  localparam bcd_field_t SEC_MAX          = 8'h59;
  localparam bcd_field_t MIN_MAX          = 8'h59;
  localparam bcd_field_t HOUR_MAX_DEFAULT = 8'h23;

  typedef enum logic {IDLE, CHECK} state_e;

  // Both digits must be decimal; for well-formed BCD a plain compare orders correctly.
  function automatic logic bcd_in_range(bcd_field_t v, bcd_field_t max);
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens = v[7:4];
    ones = v[3:0];
    return (tens <= 4'd9) && (ones <= 4'd9) && (v <= max);
  endfunction

endpackage

// File: rtl/bcd_field_cnt.sv
// Two-digit BCD counter: wraps to 00 past max_i with carry_o, load takes priority.
// Registered value, combinational carry; no backpressure.
module bcd_field_cnt
  import zegar_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  bcd_field_t max_i,
  input  logic       inc_i,
  input  logic       load_i,
  input  bcd_field_t load_dat_i,
  output bcd_field_t val_o,
  output logic       carry_o
);

  bcd_field_t val_q;
  bcd_field_t val_d;
  bcd_digit_t tens_inc;
  bcd_digit_t ones_inc;

  assign tens_inc = val_q[7:4] + 4'd1;
  assign ones_inc = val_q[3:0] + 4'd1;
  assign carry_o  = inc_i & ~load_i & (val_q == max_i);
  assign val_o    = val_q;

  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = load_dat_i;
    end else if (inc_i) begin
      if (val_q == max_i) begin
        val_d = '0;
      end else if (val_q[3:0] >= 4'd9) begin
        val_d = {tens_inc, 4'd0};
      end else begin
        val_d = {val_q[7:4], ones_inc};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) val_q <= '0;
    else         val_q <= val_d;
  end

endmodule

// File: rtl/zegar_licznik.sv
// BCD hh:mm:ss counter advanced by tick_i (or every cycle in test mode), with a validated set port.
// Time updates on the edge sampling adv; set_ready_o drops for one cycle per accepted load.
module zegar_licznik
  import zegar_pkg::*;
#(
  parameter bcd_field_t MAX_HOUR = HOUR_MAX_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       button_test_i,
  input  logic       set_valid_i,
  output logic       set_ready_o,
  input  logic [7:0] set_hour_i,
  input  logic [7:0] set_min_i,
  input  logic [7:0] set_sec_i,
  output logic       set_err_o,
  output logic [7:0] hour_o,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic       min_pulse_o,
  output logic       day_pulse_o
);

  logic       sync1_q;
  logic       test_sync_q;
  logic       adv;

  state_e     state_q,     state_d;
  bcd_field_t hold_hour_q, hold_hour_d;
  bcd_field_t hold_min_q,  hold_min_d;
  bcd_field_t hold_sec_q,  hold_sec_d;
  logic       set_err_q,   set_err_d;
  logic       min_pulse_q, day_pulse_q;

  logic       legal;
  logic       load_en;
  logic       sec_carry, min_carry, hour_carry;

  assign adv   = test_sync_q | tick_i;
  assign legal = bcd_in_range(hold_sec_q, SEC_MAX)
               & bcd_in_range(hold_min_q, MIN_MAX)
               & bcd_in_range(hold_hour_q, MAX_HOUR);

  always_comb begin
    state_d     = state_q;
    hold_hour_d = hold_hour_q;
    hold_min_d  = hold_min_q;
    hold_sec_d  = hold_sec_q;
    load_en     = 1'b0;
    set_err_d   = 1'b0;
    set_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        set_ready_o = 1'b1;
        if (set_valid_i) begin
          hold_hour_d = set_hour_i;
          hold_min_d  = set_min_i;
          hold_sec_d  = set_sec_i;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        state_d   = IDLE;
        load_en   = legal;
        set_err_d = ~legal;
      end
      default: state_d = IDLE;
    endcase
  end

  // A legal load overrides any advance in the same cycle, so the carry chain sees no inc.
  bcd_field_cnt u_sec (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .max_i      (SEC_MAX),
    .inc_i      (adv & ~load_en),
    .load_i     (load_en),
    .load_dat_i (hold_sec_q),
    .val_o      (sec_o),
    .carry_o    (sec_carry)
  );

  bcd_field_cnt u_min (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .max_i      (MIN_MAX),
    .inc_i      (sec_carry),
    .load_i     (load_en),
    .load_dat_i (hold_min_q),
    .val_o      (min_o),
    .carry_o    (min_carry)
  );

  bcd_field_cnt u_hour (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .max_i      (MAX_HOUR),
    .inc_i      (min_carry),
    .load_i     (load_en),
    .load_dat_i (hold_hour_q),
    .val_o      (hour_o),
    .carry_o    (hour_carry)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b0;
      test_sync_q <= 1'b0;
      state_q     <= IDLE;
      hold_hour_q <= '0;
      hold_min_q  <= '0;
      hold_sec_q  <= '0;
      set_err_q   <= 1'b0;
      min_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      sync1_q     <= button_test_i;
      test_sync_q <= sync1_q;
      state_q     <= state_d;
      hold_hour_q <= hold_hour_d;
      hold_min_q  <= hold_min_d;
      hold_sec_q  <= hold_sec_d;
      set_err_q   <= set_err_d;
      min_pulse_q <= sec_carry;
      day_pulse_q <= hour_carry;
    end
  end

  assign set_err_o   = set_err_q;
  assign min_pulse_o = min_pulse_q;
  assign day_pulse_o = day_pulse_q;

endmodule

// File: tb/tb_zegar_licznik.sv
// Directed bench for zegar_licznik: reset, loads, tick/load interaction, test mode, mid-op reset.
module tb_zegar_licznik;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       tick_i;
  logic       button_test_i;
  logic       set_valid_i;
  logic       set_ready_o;
  logic [7:0] set_hour_i, set_min_i, set_sec_i;
  logic       set_err_o;
  logic [7:0] hour_o, min_o, sec_o;
  logic       min_pulse_o, day_pulse_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  zegar_licznik #(.MAX_HOUR(8'h23)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .tick_i        (tick_i),
    .button_test_i (button_test_i),
    .set_valid_i   (set_valid_i),
    .set_ready_o   (set_ready_o),
    .set_hour_i    (set_hour_i),
    .set_min_i     (set_min_i),
    .set_sec_i     (set_sec_i),
    .set_err_o     (set_err_o),
    .hour_o        (hour_o),
    .min_o         (min_o),
    .sec_o         (sec_o),
    .min_pulse_o   (min_pulse_o),
    .day_pulse_o   (day_pulse_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [23:0] now_t();
    return {hour_o, min_o, sec_o};
  endfunction

  task automatic put_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_hour_i = h;
    set_min_i  = m;
    set_sec_i  = s;
  endtask

  task automatic test_reset();
    int pulses;
    rst_ni = 1'b0; tick_i = 1'b0; button_test_i = 1'b0; set_valid_i = 1'b0;
    put_set(8'h00, 8'h00, 8'h00);
    step(); step();
    n_checks++;
    if (now_t() !== 24'h000000) begin n_fail++; $display("FAIL reset_time got %h want 000000", now_t()); end
    n_checks++;
    if ({set_ready_o, set_err_o, min_pulse_o, day_pulse_o} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags got %b want 1000", {set_ready_o, set_err_o, min_pulse_o, day_pulse_o});
    end
    rst_ni = 1'b1;
    pulses = 0;
    tick_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (min_pulse_o === 1'b1) pulses++;
    end
    tick_i = 1'b0;
    step();
    if (min_pulse_o === 1'b1) pulses++;
    n_checks++;
    if (now_t() !== 24'h000100) begin n_fail++; $display("FAIL sixty_ticks got %h want 000100", now_t()); end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL min_pulse_count got %0d want 1", pulses); end
  endtask

  task automatic test_legal_load();
    put_set(8'h23, 8'h59, 8'h58);
    set_valid_i = 1'b1;
    step();
    n_checks++;
    if (set_ready_o !== 1'b0) begin n_fail++; $display("FAIL legal_ready_low got %b want 0", set_ready_o); end
    set_valid_i = 1'b0;
    step();
    n_checks++;
    if ({now_t(), set_err_o, set_ready_o} !== {24'h235958, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL legal_load got %h err %b rdy %b want 235958 err 0 rdy 1", now_t(), set_err_o, set_ready_o);
    end
    tick_i = 1'b1;
    step();
    n_checks++;
    if ({now_t(), min_pulse_o} !== {24'h235959, 1'b0}) begin
      n_fail++; $display("FAIL pre_wrap got %h mp %b want 235959 mp 0", now_t(), min_pulse_o);
    end
    step();
    tick_i = 1'b0;
    n_checks++;
    if ({now_t(), day_pulse_o, min_pulse_o} !== {24'h000000, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL day_wrap got %h dp %b mp %b want 000000 dp 1 mp 1", now_t(), day_pulse_o, min_pulse_o);
    end
    step();
    n_checks++;
    if ({now_t(), day_pulse_o, min_pulse_o} !== {24'h000000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL day_pulse_width got %h dp %b mp %b want 000000 dp 0 mp 0", now_t(), day_pulse_o, min_pulse_o);
    end
  endtask

  task automatic test_illegal_loads();
    logic [23:0] vec [3];
    logic [23:0] v;
    vec[0] = 24'h126000;
    vec[1] = 24'h240000;
    vec[2] = 24'h00001A;
    for (int i = 0; i < 3; i++) begin
      v = vec[i];
      put_set(v[23:16], v[15:8], v[7:0]);
      set_valid_i = 1'b1;
      step();
      set_valid_i = 1'b0;
      n_checks++;
      if (set_ready_o !== 1'b0) begin n_fail++; $display("FAIL illegal%0d_ready got %b want 0", i, set_ready_o); end
      step();
      n_checks++;
      if ({set_err_o, set_ready_o, now_t()} !== {1'b1, 1'b1, 24'h000000}) begin
        n_fail++; $display("FAIL illegal%0d_err got err %b rdy %b t %h want err 1 rdy 1 t 000000", i, set_err_o, set_ready_o, now_t());
      end
      step();
      n_checks++;
      if (set_err_o !== 1'b0) begin n_fail++; $display("FAIL illegal%0d_err_width got %b want 0", i, set_err_o); end
    end
  endtask

  task automatic test_tick_in_check();
    put_set(8'h10, 8'h00, 8'h00);
    set_valid_i = 1'b1;
    step();
    set_valid_i = 1'b0;
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    n_checks++;
    if ({now_t(), set_err_o} !== {24'h100000, 1'b0}) begin
      n_fail++; $display("FAIL legal_tick_discard got %h err %b want 100000 err 0", now_t(), set_err_o);
    end
    put_set(8'h25, 8'h00, 8'h00);
    set_valid_i = 1'b1;
    step();
    set_valid_i = 1'b0;
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    n_checks++;
    if ({now_t(), set_err_o} !== {24'h100001, 1'b1}) begin
      n_fail++; $display("FAIL illegal_tick_kept got %h err %b want 100001 err 1", now_t(), set_err_o);
    end
    put_set(8'h09, 8'h59, 8'h59);
    set_valid_i = 1'b1;
    tick_i = 1'b1;
    step();
    set_valid_i = 1'b0;
    tick_i = 1'b0;
    n_checks++;
    if ({now_t(), set_ready_o} !== {24'h100002, 1'b0}) begin
      n_fail++; $display("FAIL accept_cycle_tick got %h rdy %b want 100002 rdy 0", now_t(), set_ready_o);
    end
    step();
    n_checks++;
    if ({now_t(), min_pulse_o, day_pulse_o} !== {24'h095959, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL accept_then_load got %h mp %b dp %b want 095959 mp 0 dp 0", now_t(), min_pulse_o, day_pulse_o);
    end
  endtask

  task automatic test_back_to_back();
    put_set(8'h01, 8'h02, 8'h03);
    set_valid_i = 1'b1;
    step();
    put_set(8'h04, 8'h05, 8'h06);
    n_checks++;
    if (set_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready1 got %b want 0", set_ready_o); end
    step();
    n_checks++;
    if ({set_ready_o, now_t()} !== {1'b1, 24'h010203}) begin
      n_fail++; $display("FAIL b2b_first got rdy %b t %h want rdy 1 t 010203", set_ready_o, now_t());
    end
    step();
    set_valid_i = 1'b0;
    n_checks++;
    if (set_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready2 got %b want 0", set_ready_o); end
    step();
    n_checks++;
    if ({set_ready_o, now_t()} !== {1'b1, 24'h040506}) begin
      n_fail++; $display("FAIL b2b_second got rdy %b t %h want rdy 1 t 040506", set_ready_o, now_t());
    end
  endtask

  task automatic test_test_mode();
    int days;
    put_set(8'h00, 8'h00, 8'h00);
    set_valid_i = 1'b1;
    step();
    set_valid_i = 1'b0;
    step();
    n_checks++;
    if ({now_t(), min_pulse_o, day_pulse_o} !== {24'h000000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL zero_load_no_pulse got %h mp %b dp %b want 000000 mp 0 dp 0", now_t(), min_pulse_o, day_pulse_o);
    end
    button_test_i = 1'b1;
    step(); step();
    n_checks++;
    if (now_t() !== 24'h000000) begin n_fail++; $display("FAIL test_sync_latency got %h want 000000", now_t()); end
    step();
    n_checks++;
    if (now_t() !== 24'h000001) begin n_fail++; $display("FAIL test_first_adv got %h want 000001", now_t()); end
    days = 0;
    for (int i = 1; i < 86400; i++) begin
      step();
      if (day_pulse_o === 1'b1) days++;
    end
    n_checks++;
    if ({now_t(), day_pulse_o} !== {24'h000000, 1'b1}) begin
      n_fail++; $display("FAIL full_day got %h dp %b want 000000 dp 1", now_t(), day_pulse_o);
    end
    n_checks++;
    if (days !== 1) begin n_fail++; $display("FAIL full_day_pulses got %0d want 1", days); end
    button_test_i = 1'b0;
    step(); step();
    n_checks++;
    if (now_t() !== 24'h000002) begin n_fail++; $display("FAIL release_latency got %h want 000002", now_t()); end
    step();
    n_checks++;
    if (now_t() !== 24'h000002) begin n_fail++; $display("FAIL release_stops got %h want 000002", now_t()); end
  endtask

  task automatic test_reset_mid();
    put_set(8'h12, 8'h34, 8'h56);
    set_valid_i = 1'b1;
    step();
    set_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({now_t(), set_ready_o, set_err_o} !== {24'h000000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rst_in_check got %h rdy %b err %b want 000000 rdy 1 err 0", now_t(), set_ready_o, set_err_o);
    end
    step();
    rst_ni = 1'b1;
    step();
    n_checks++;
    if ({now_t(), set_ready_o, set_err_o} !== {24'h000000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL load_aborted got %h rdy %b err %b want 000000 rdy 1 err 0", now_t(), set_ready_o, set_err_o);
    end
    tick_i = 1'b1;
    step(); step(); step();
    tick_i = 1'b0;
    n_checks++;
    if (now_t() !== 24'h000003) begin n_fail++; $display("FAIL count_after_rst got %h want 000003", now_t()); end
    button_test_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (now_t() !== 24'h000006) begin n_fail++; $display("FAIL test_mode_before_rst got %h want 000006", now_t()); end
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({now_t(), min_pulse_o, day_pulse_o} !== {24'h000000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rst_in_test_mode got %h mp %b dp %b want 000000 mp 0 dp 0", now_t(), min_pulse_o, day_pulse_o);
    end
    button_test_i = 1'b0;
    step(); step();
    rst_ni = 1'b1;
    step(); step(); step();
    n_checks++;
    if (now_t() !== 24'h000000) begin n_fail++; $display("FAIL idle_after_rst got %h want 000000", now_t()); end
    tick_i = 1'b1;
    step(); step();
    tick_i = 1'b0;
    n_checks++;
    if (now_t() !== 24'h000002) begin n_fail++; $display("FAIL tick_after_rst got %h want 000002", now_t()); end
  endtask

  initial begin
    test_reset();
    test_legal_load();
    test_illegal_loads();
    test_tick_in_check();
    test_back_to_back();
    test_test_mode();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
